// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with a valid/ready input
// handshake and a registered, held BCD result for the display decoders.
module bin_to_bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_a,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  in_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  out_valid,
    output logic                  overflow
);

    localparam int SW = 4 * DIGITS;
    localparam int IW = $clog2(WIDTH + 1);
    localparam logic [IW-1:0] LAST_ITER = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_sreg;
    logic [SW-1:0]      r_scratch;
    logic               r_ovf_acc;
    logic [IW-1:0]      r_iter;
    logic [SW-1:0]      r_bcd;
    logic               r_overflow;
    logic               r_out_valid;
    logic               r_in_ready;

    logic [SW-1:0]      w_adj;

    // Add-3 correction is per digit with no carry; digits above 4 would exceed 9 after doubling.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign w_adj[4*gi +: 4] = (r_scratch[4*gi +: 4] >= 4'd5)
                                      ? r_scratch[4*gi +: 4] + 4'd3
                                      : r_scratch[4*gi +: 4];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            r_state     <= S_IDLE;
            r_sreg      <= '0;
            r_scratch   <= '0;
            r_ovf_acc   <= 1'b0;
            r_iter      <= '0;
            r_bcd       <= '0;
            r_overflow  <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_sreg     <= bin_in;
                        r_scratch  <= '0;
                        r_ovf_acc  <= 1'b0;
                        r_iter     <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // A bit leaving the top digit means the value needs more digits than we have.
                    r_scratch <= {w_adj[SW-2:0], r_sreg[WIDTH-1]};
                    r_sreg    <= {r_sreg[WIDTH-2:0], 1'b0};
                    r_ovf_acc <= r_ovf_acc | w_adj[SW-1];
                    r_iter    <= r_iter + IW'(1);
                    if (r_iter == LAST_ITER) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_bcd       <= r_scratch;
                    r_overflow  <= r_ovf_acc;
                    r_out_valid <= 1'b1;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign bcd_out   = r_bcd;
    assign out_valid = r_out_valid;
    assign overflow  = r_overflow;

endmodule
